// File: rtl/lcd_window_scaler.sv
// RGB-LCD timing generator with a runtime-placed, power-of-two-scaled video-RAM window.
// Three-stage pipeline: counters -> RAM address/timing flags -> pixel/timing outputs.
module lcd_window_scaler #(
  parameter int unsigned H_ACTIVE   = 480,
  parameter int unsigned H_FP       = 8,
  parameter int unsigned H_SYNC     = 4,
  parameter int unsigned H_BP       = 43,
  parameter int unsigned V_ACTIVE   = 272,
  parameter int unsigned V_FP       = 8,
  parameter int unsigned V_SYNC     = 4,
  parameter int unsigned V_BP       = 12,
  parameter int unsigned WIN_W_LOG2 = 6,
  parameter int unsigned WIN_H_LOG2 = 6,
  parameter int unsigned DATA_W     = 8,
  parameter bit          SYNC_POL   = 1'b0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [15:0]                      cfg_win_x,
  input  logic [15:0]                      cfg_win_y,
  input  logic [1:0]                       cfg_scale,
  input  logic                             cfg_win_en,
  input  logic [15:0]                      cfg_bg,
  output logic [WIN_W_LOG2+WIN_H_LOG2-1:0] ram_addr,
  output logic                             ram_rd_en,
  input  logic [DATA_W-1:0]                ram_data,
  output logic                             lcd_hsync,
  output logic                             lcd_vsync,
  output logic                             lcd_den,
  output logic [4:0]                       lcd_r,
  output logic [5:0]                       lcd_g,
  output logic [4:0]                       lcd_b,
  output logic                             frame_start,
  output logic                             line_start
);

  localparam int unsigned CW       = 16;
  localparam int unsigned H_TOTAL  = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL  = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned HA_START = H_SYNC + H_BP;
  localparam int unsigned HA_END   = HA_START + H_ACTIVE;
  localparam int unsigned VA_START = V_SYNC + V_BP;
  localparam int unsigned VA_END   = VA_START + V_ACTIVE;

  logic [CW-1:0] h, v;
  logic [15:0]   sh_x, sh_y, sh_bg;
  logic [1:0]    sh_scale;
  logic          sh_en;

  logic                  origin_c, hs_c, vs_c, den_c, in_x_c, in_y_c, in_win_c;
  logic [CW-1:0]         ax_c, ay_c;
  logic [16:0]           span_w_c, span_h_c, dx_c, dy_c;
  logic [WIN_W_LOG2-1:0] col_c;
  logic [WIN_H_LOG2-1:0] row_c;
  logic [15:0]           ram_pix_c;

  logic den1, hs1, vs1, win1, fs1, ls1;
  logic use_ram;
  logic [15:0] bg2;

  // Stage 0: free-running raster counters
  always_ff @(posedge clk) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (h == CW'(H_TOTAL - 1)) begin
      h <= '0;
      v <= (v == CW'(V_TOTAL - 1)) ? '0 : v + CW'(1);
    end else begin
      h <= h + CW'(1);
    end
  end

  // Window config is frozen for the whole frame once sampled at the raster origin
  always_ff @(posedge clk) begin
    if (rst || origin_c) begin
      sh_x     <= cfg_win_x;
      sh_y     <= cfg_win_y;
      sh_scale <= cfg_scale;
      sh_en    <= cfg_win_en;
      sh_bg    <= cfg_bg;
    end
  end

  assign origin_c = (h == '0) && (v == '0);
  assign hs_c     = h < CW'(H_SYNC);
  assign vs_c     = v < CW'(V_SYNC);
  assign den_c    = (h >= CW'(HA_START)) && (h < CW'(HA_END)) &&
                    (v >= CW'(VA_START)) && (v < CW'(VA_END));
  assign ax_c     = h - CW'(HA_START);
  assign ay_c     = v - CW'(VA_START);

  // 17-bit compare so a window near 16'hFFFF cannot wrap back into view
  assign span_w_c = 17'(1 << WIN_W_LOG2) << sh_scale;
  assign span_h_c = 17'(1 << WIN_H_LOG2) << sh_scale;
  assign in_x_c   = ({1'b0, ax_c} >= {1'b0, sh_x}) && ({1'b0, ax_c} < ({1'b0, sh_x} + span_w_c));
  assign in_y_c   = ({1'b0, ay_c} >= {1'b0, sh_y}) && ({1'b0, ay_c} < ({1'b0, sh_y} + span_h_c));
  assign in_win_c = sh_en && den_c && in_x_c && in_y_c;
  assign dx_c     = {1'b0, ax_c} - {1'b0, sh_x};
  assign dy_c     = {1'b0, ay_c} - {1'b0, sh_y};
  assign col_c    = WIN_W_LOG2'(dx_c >> sh_scale);
  assign row_c    = WIN_H_LOG2'(dy_c >> sh_scale);

  // Stage 1: RAM request plus delayed timing flags
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr  <= '0;
      ram_rd_en <= 1'b0;
      den1      <= 1'b0;
      hs1       <= 1'b0;
      vs1       <= 1'b0;
      win1      <= 1'b0;
      fs1       <= 1'b0;
      ls1       <= 1'b0;
    end else begin
      if (in_win_c) ram_addr <= {row_c, col_c};
      ram_rd_en <= in_win_c;
      den1      <= den_c;
      hs1       <= hs_c;
      vs1       <= vs_c;
      win1      <= in_win_c;
      fs1       <= origin_c;
      ls1       <= (h == '0);
    end
  end

  // Stage 2: timing outputs and colour select
  always_ff @(posedge clk) begin
    if (rst) begin
      lcd_hsync   <= ~SYNC_POL;
      lcd_vsync   <= ~SYNC_POL;
      lcd_den     <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      use_ram     <= 1'b0;
      bg2         <= '0;
    end else begin
      lcd_hsync   <= hs1 ? SYNC_POL : ~SYNC_POL;
      lcd_vsync   <= vs1 ? SYNC_POL : ~SYNC_POL;
      lcd_den     <= den1;
      frame_start <= fs1;
      line_start  <= ls1;
      use_ram     <= den1 && win1;
      bg2         <= (den1 && !win1) ? sh_bg : 16'h0000;
    end
  end

  if (DATA_W == 16) begin : g_rgb565
    assign ram_pix_c = 16'(ram_data);
  end else begin : g_gray
    logic unused_lsbs;
    assign unused_lsbs = ^ram_data[1:0];
    assign ram_pix_c   = {ram_data[7:3], ram_data[7:2], ram_data[7:3]};
  end

  // RAM output is already a register, so the colour mux sits after the stage-2 select
  assign {lcd_r, lcd_g, lcd_b} = use_ram ? ram_pix_c : bg2;

endmodule

// File: tb/tb_lcd_window_scaler.sv
// Scoreboard bench: arithmetic raster model predicts every output cycle; a monitor pops and compares.
module tb_lcd_window_scaler;

  localparam int HT    = 535;
  localparam int VT    = 20;
  localparam int FRAME = HT * VT;
  localparam int HA0   = 47;
  localparam int VA0   = 4;
  localparam int VACT  = 14;
  localparam int RST_AT = 3 * FRAME + HT * 8 + 200;
  localparam int G_END  = 6 * FRAME + 50;
  localparam int S_HT   = 119;
  localparam int S_FRAME = 119 * 32;

  typedef struct {
    logic        hs, vs, den, fs, ls;
    logic [15:0] rgb;
    logic        rd;
    logic [11:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst, s_rst;
  logic [15:0] cfg_win_x, cfg_win_y, cfg_bg;
  logic [1:0]  cfg_scale;
  logic        cfg_win_en;
  logic [11:0] ram_addr;
  logic        ram_rd_en;
  logic [7:0]  ram_data;
  logic        lcd_hsync, lcd_vsync, lcd_den, frame_start, line_start;
  logic [4:0]  lcd_r, lcd_b;
  logic [5:0]  lcd_g;

  logic [11:0] s_ram_addr;
  logic        s_ram_rd_en;
  logic [7:0]  s_ram_data;
  logic        s_hsync, s_vsync, s_den, s_fs, s_ls;
  logic [4:0]  s_r, s_b;
  logic [5:0]  s_g;

  logic [7:0] mem [4096];
  exp_t q[$];

  int n_cmp = 0, n_bad = 0, n_fs_chk = 0;
  int sx, sy, ss, last_addr;
  bit sen;
  logic [15:0] sbg;

  always #5 clk = ~clk;

  lcd_window_scaler #(.V_ACTIVE(VACT), .V_FP(2), .V_SYNC(2), .V_BP(2)) u_dut (
    .clk(clk), .rst(rst), .cfg_win_x(cfg_win_x), .cfg_win_y(cfg_win_y),
    .cfg_scale(cfg_scale), .cfg_win_en(cfg_win_en), .cfg_bg(cfg_bg),
    .ram_addr(ram_addr), .ram_rd_en(ram_rd_en), .ram_data(ram_data),
    .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync), .lcd_den(lcd_den),
    .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b),
    .frame_start(frame_start), .line_start(line_start));

  lcd_window_scaler #(.SYNC_POL(1'b1), .H_ACTIVE(64), .V_ACTIVE(8)) u_small (
    .clk(clk), .rst(s_rst), .cfg_win_x(16'd0), .cfg_win_y(16'd0),
    .cfg_scale(2'd0), .cfg_win_en(1'b0), .cfg_bg(16'h07E0),
    .ram_addr(s_ram_addr), .ram_rd_en(s_ram_rd_en), .ram_data(s_ram_data),
    .lcd_hsync(s_hsync), .lcd_vsync(s_vsync), .lcd_den(s_den),
    .lcd_r(s_r), .lcd_g(s_g), .lcd_b(s_b),
    .frame_start(s_fs), .line_start(s_ls));

  // one-cycle-latency synchronous RAM
  always @(posedge clk) if (ram_rd_en) ram_data <= mem[ram_addr];
  assign s_ram_data = 8'h00;

  function automatic exp_t model_at(int unsigned nn);
    exp_t e;
    int h, v, ax, ay, d, span;
    bit den, inwin;
    h = int'(nn % HT);
    v = int'((nn / HT) % VT);
    ax = h - HA0;
    ay = v - VA0;
    den = (h >= HA0) && (h < HA0 + 480) && (v >= VA0) && (v < VA0 + VACT);
    span = 64 << ss;
    inwin = sen && den && (ax >= sx) && (ax < sx + span) && (ay >= sy) && (ay < sy + span);
    if (inwin) last_addr = (((ay - sy) >> ss) % 64) * 64 + (((ax - sx) >> ss) % 64);
    e.hs = !(h < 4);
    e.vs = !(v < 2);
    e.den = den;
    e.fs = (h == 0) && (v == 0);
    e.ls = (h == 0);
    e.rd = inwin;
    e.addr = 12'(last_addr);
    if (!den) e.rgb = 16'h0000;
    else if (inwin) begin
      d = int'(mem[last_addr]);
      e.rgb = 16'((d >> 3) * 2048 + (d >> 2) * 32 + (d >> 3));
    end else e.rgb = sbg;
    return e;
  endfunction

  // stimulus + reference model
  initial begin
    exp_t e;
    int unsigned n;
    int g, k, chg_at;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    rst = 1'b1; s_rst = 1'b1;
    cfg_win_x = 16'd0; cfg_win_y = 16'd0; cfg_scale = 2'd0;
    cfg_win_en = 1'b0; cfg_bg = 16'hF800;
    n = 0; g = 0; k = 0; last_addr = 0;
    chg_at = HT * 10 + int'($urandom_range(0, HT - 1));
    while (g < G_END) begin
      @(negedge clk);
      g++;
      rst = (g < 4) || (g >= RST_AT && g < RST_AT + 3);
      s_rst = (g < 4);
      if (!rst && int'(n % FRAME) == chg_at) begin
        case (k)
          0: begin cfg_win_x = 16'd160; cfg_win_y = 16'd8; cfg_scale = 2'd2; cfg_win_en = 1'b1; end
          1: begin cfg_win_x = 16'd450; cfg_win_y = 16'd10; cfg_scale = 2'd0; cfg_win_en = 1'b1; end
          2: begin cfg_win_x = 16'hFFF0; cfg_win_y = 16'd0; cfg_scale = 2'd3; cfg_win_en = 1'b1; end
          default: begin
            cfg_win_x = 16'($urandom_range(0, 520));
            cfg_win_y = 16'($urandom_range(0, 20));
            cfg_scale = 2'($urandom);
            cfg_win_en = ($urandom_range(0, 3) != 0);
          end
        endcase
        cfg_bg = 16'($urandom);
        k++;
        chg_at = HT * 10 + int'($urandom_range(0, HT - 1));
      end
      if (rst) begin
        if (q.size() > 0) begin
          e = q.pop_back();
          e.hs = 1'b1; e.vs = 1'b1; e.den = 1'b0; e.rgb = 16'h0000; e.fs = 1'b0; e.ls = 1'b0;
          q.push_back(e);
        end
        e.hs = 1'b1; e.vs = 1'b1; e.den = 1'b0; e.rgb = 16'h0000;
        e.fs = 1'b0; e.ls = 1'b0; e.rd = 1'b0; e.addr = 12'h000;
        q.push_back(e);
        sx = int'(cfg_win_x); sy = int'(cfg_win_y); ss = int'(cfg_scale);
        sen = cfg_win_en; sbg = cfg_bg; last_addr = 0; n = 0;
      end else begin
        e = model_at(n);
        q.push_back(e);
        if (n % FRAME == 0) begin
          sx = int'(cfg_win_x); sy = int'(cfg_win_y); ss = int'(cfg_scale);
          sen = cfg_win_en; sbg = cfg_bg;
        end
        n++;
      end
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (n_fs_chk < 4) begin
      n_bad++;
      $display("FAIL fs_period_count: got %0d checked periods, want >= 4", n_fs_chk);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // monitor
  exp_t me;
  logic        prev_rd;
  logic [11:0] prev_addr;
  int mcyc = 0, last_fs = -1, s_last_fs = -1, s_last_ls = -1, s_hs_cnt = 0;
  bit rst_gap = 1'b0;

  always @(posedge clk) begin
    #1;
    mcyc++;
    if (q.size() >= 2) begin
      me = q.pop_front();
      n_cmp++;
      if ({lcd_hsync, lcd_vsync, lcd_den, frame_start, line_start} !== {me.hs, me.vs, me.den, me.fs, me.ls} ||
          {lcd_r, lcd_g, lcd_b} !== me.rgb) begin
        n_bad++;
        $display("FAIL pix @%0d: got hs/vs/den/fs/ls=%b%b%b%b%b rgb=%h, want %b%b%b%b%b rgb=%h",
                 mcyc, lcd_hsync, lcd_vsync, lcd_den, frame_start, line_start, {lcd_r, lcd_g, lcd_b},
                 me.hs, me.vs, me.den, me.fs, me.ls, me.rgb);
      end
      n_cmp++;
      if (prev_rd !== me.rd || prev_addr !== me.addr) begin
        n_bad++;
        $display("FAIL ram @%0d: got rd=%b addr=%0d, want rd=%b addr=%0d",
                 mcyc, prev_rd, prev_addr, me.rd, me.addr);
      end
    end
    prev_rd = ram_rd_en;
    prev_addr = ram_addr;

    if (rst) rst_gap = 1'b1;
    if (frame_start === 1'b1) begin
      if (last_fs >= 0 && !rst_gap) begin
        n_cmp++; n_fs_chk++;
        if (mcyc - last_fs != FRAME) begin
          n_bad++;
          $display("FAIL fs_period: got %0d, want %0d", mcyc - last_fs, FRAME);
        end
      end
      last_fs = mcyc;
      rst_gap = 1'b0;
    end

    if (!s_rst) begin
      if (s_fs === 1'b1) begin
        n_cmp++;
        if (s_vsync !== 1'b1 || s_hsync !== 1'b1 || (s_last_fs >= 0 && mcyc - s_last_fs != S_FRAME)) begin
          n_bad++;
          $display("FAIL small_frame: got vs=%b hs=%b period=%0d, want 1 1 %0d",
                   s_vsync, s_hsync, mcyc - s_last_fs, S_FRAME);
        end
        s_last_fs = mcyc;
      end
      if (s_ls === 1'b1) begin
        if (s_last_ls >= 0) begin
          n_cmp++;
          if (mcyc - s_last_ls != S_HT || s_hs_cnt != 4 || s_hsync !== 1'b1) begin
            n_bad++;
            $display("FAIL small_line: got period=%0d hs_cycles=%0d hs=%b, want %0d 4 1",
                     mcyc - s_last_ls, s_hs_cnt, s_hsync, S_HT);
          end
        end
        s_last_ls = mcyc;
        s_hs_cnt = 0;
      end
      if (s_hsync === 1'b1) s_hs_cnt++;
    end
  end

endmodule
